sram_port_sequencer: RTL and testbench

Front-end sequencer for one single-port, one-cycle-read `*_ext` SRAM macro, such as `data_arrays_0_ext` (ADDR_W=9, DATA_W=256, MASK_W=32).
- After reset it zero-fills the whole array.
- It then accepts read/write requests on a valid/ready interface and drives the macro's RW0 port.
- It captures read data into a small response FIFO so that consumers can apply backpressure.
- It sits directly upstream of the macro and replaces ad-hoc en/wmode glue in the cache and data-array wrappers.

---
 rtl/sram_seq_pkg.sv | 14 +
 rtl/sram_port_sequencer_if.sv | 26 ++
 rtl/sram_port_sequencer_resp_fifo.sv | 57 +++++
 rtl/sram_port_sequencer.sv | 102 ++++++++++
 tb/tb_sram_port_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_seq_pkg.sv
// Shared state type and lane-width helper for the SRAM port sequencer slice.
package sram_seq_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic int unsigned lane_width(input int unsigned data_w,
                                             input int unsigned mask_w);
    return data_w / mask_w;
  endfunction

endpackage

// File: rtl/sram_port_sequencer_if.sv
// Request/response handshake bundle between a client and the SRAM sequencer.
interface sram_port_sequencer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned MASK_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_port_sequencer_resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module sram_resp_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/sram_port_sequencer.sv
// Drives one single-port SRAM macro: zero-fill after reset, then in-order
// read/write requests with read data buffered in a credit-protected FIFO.
module sram_port_sequencer
  import sram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned MASK_W        = 32,
  parameter int unsigned RESP_DEPTH    = 3,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  sram_port_sequencer_if.slave bus,
  output logic                 init_done,
  output logic                 sram_en,
  output logic                 sram_wmode,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [MASK_W-1:0]    sram_wmask,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata
);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q, inflight_d;
  logic              fire;
  logic              resp_pop;
  logic [CNT_W-1:0]  resp_count;
  logic [CNT_W:0]    credit_used;
  logic [DATA_W-1:0] resp_head;

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  assign credit_used   = {1'b0, resp_count} + {{CNT_W{1'b0}}, inflight_q};
  assign bus.req_ready = !reset && (state_q == S_RUN) &&
                         (credit_used < (CNT_W + 1)'(RESP_DEPTH));
  assign bus.resp_valid = !reset && (resp_count != '0);
  assign bus.resp_rdata = resp_head;
  assign resp_pop       = bus.resp_valid && bus.resp_ready;
  assign init_done      = !reset && (state_q == S_RUN);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    fire       = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = bus.req_addr;
    sram_wmask = '0;
    sram_wdata = '0;
    unique case (state_q)
      S_INIT: begin
        sram_en    = !reset;
        sram_wmode = !reset;
        sram_addr  = init_cnt_q;
        sram_wmask = '1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == '1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        fire       = bus.req_valid && bus.req_ready;
        sram_en    = fire;
        sram_wmode = fire && bus.req_write;
        if (fire) begin
          sram_wmask = bus.req_wmask;
          sram_wdata = bus.req_wdata;
        end
      end
      default: ;
    endcase
    inflight_d = fire && !bus.req_write;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT_ON_RESET ? S_INIT : S_RUN;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (sram_rdata),
    .pop_i       (resp_pop),
    .head_o      (resp_head),
    .count_o     (resp_count)
  );
endmodule

// File: tb/tb_sram_port_sequencer.sv
// Directed bench for sram_port_sequencer with a behavioural one-cycle-read SRAM.
module tb_sram_port_sequencer;
  import sram_seq_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 256;
  localparam int unsigned MW    = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned LW    = lane_width(DW, MW);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_port_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  logic          init_done, sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [DW-1:0] mem [1 << AW];

  int tests = 0;
  int fails = 0;

  sram_port_sequencer #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .MASK_W        (MW),
    .RESP_DEPTH    (DEPTH),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Macro model: starts with garbage so only the zero-fill can produce zeros.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] = sram_wdata[l*LW +: LW];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  function automatic logic [DW-1:0] dpat(input int k);
    return {16{16'hC000 | 16'(k)}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
  endtask

  task automatic sweep_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("sweep_en", sram_en, 1);
      check("sweep_wmode", sram_wmode, 1);
      check("sweep_addr", sram_addr, i);
      check("sweep_wmask", sram_wmask, {MW{1'b1}});
      check("sweep_wdata", sram_wdata, 0);
      check("sweep_ready", bus.req_ready, 0);
      check("sweep_init_done", init_done, 0);
      next();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {8{32'hDEAD_0000 | 32'(i)}};
  end

  initial begin
    reset = 1'b1;
    idle();
    bus.resp_ready = 1'b0;
    repeat (3) next();
    @(negedge clock);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_sram_en", sram_en, 0);

    next();
    reset = 1'b0;
    sweep_cycles(16);

    drive_read(5);
    @(negedge clock);
    check("init_done_rise", init_done, 1);
    check("rd5_ready", bus.req_ready, 1);
    check("rd5_en", sram_en, 1);
    check("rd5_wmode", sram_wmode, 0);
    check("rd5_addr", sram_addr, 5);
    next();
    idle();
    bus.req_write = 1'b1;
    bus.req_wmask = '1;
    bus.req_wdata = '1;
    @(negedge clock);
    check("rd5_lat1", bus.resp_valid, 0);
    check("idle_en", sram_en, 0);
    check("idle_wmode", sram_wmode, 0);
    check("idle_wmask", sram_wmask, 0);
    check("idle_wdata", sram_wdata, 0);
    next();
    idle();
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("rd5_valid", bus.resp_valid, 1);
    check("rd5_data", bus.resp_rdata, 0);
    next();
    @(negedge clock);
    check("rd5_popped", bus.resp_valid, 0);

    // Partial-mask write followed immediately by a read of the same word.
    next();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_wmask = 32'h0000_0001;
    bus.req_wdata = {32{8'hA5}};
    @(negedge clock);
    check("wr3_ready", bus.req_ready, 1);
    check("wr3_wmode", sram_wmode, 1);
    check("wr3_wmask", sram_wmask, 32'h1);
    check("wr3_wdata", sram_wdata, {32{8'hA5}});
    next();
    drive_read(3);
    @(negedge clock);
    check("rd3_ready", bus.req_ready, 1);
    check("rd3_wmode", sram_wmode, 0);
    next();
    idle();
    @(negedge clock);
    check("rd3_lat1", bus.resp_valid, 0);
    next();
    @(negedge clock);
    check("rd3_valid", bus.resp_valid, 1);
    check("rd3_data", bus.resp_rdata, 256'hA5);
    next();
    @(negedge clock);
    check("rd3_popped", bus.resp_valid, 0);

    for (int k = 0; k < 16; k++) begin
      next();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = AW'(k);
      bus.req_wmask = '1;
      bus.req_wdata = dpat(k);
      @(negedge clock);
      check("wr_ready", bus.req_ready, 1);
    end
    next();
    idle();
    @(negedge clock);
    check("wr_no_resp", bus.resp_valid, 0);

    // Backpressure: three credits, then stall until a pop.
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next();
      drive_read(AW'(8 + ((c < 3) ? c : 3)));
      @(negedge clock);
      check("bp_ready", bus.req_ready, (c < 3) ? 1 : 0);
    end
    next();
    drive_read(11);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("bp_stall_ready", bus.req_ready, 0);
    check("bp_head0_valid", bus.resp_valid, 1);
    check("bp_head0", bus.resp_rdata, dpat(8));
    next();
    @(negedge clock);
    check("bp_recover_ready", bus.req_ready, 1);
    check("bp_head1", bus.resp_rdata, dpat(9));
    next();
    idle();
    @(negedge clock);
    check("bp_head2", bus.resp_rdata, dpat(10));
    next();
    @(negedge clock);
    check("bp_head3_valid", bus.resp_valid, 1);
    check("bp_head3", bus.resp_rdata, dpat(11));
    next();
    @(negedge clock);
    check("bp_drained", bus.resp_valid, 0);

    for (int r = 0; r < 34; r++) begin
      next();
      if (r < 32) drive_read(AW'(r));
      else idle();
      @(negedge clock);
      if (r < 32) check("b2b_ready", bus.req_ready, 1);
      if (r >= 2) begin
        check("b2b_valid", bus.resp_valid, 1);
        check("b2b_data", bus.resp_rdata, dpat((r - 2) % 16));
      end else begin
        check("b2b_empty", bus.resp_valid, 0);
      end
    end
    next();
    idle();
    @(negedge clock);
    check("b2b_drained", bus.resp_valid, 0);

    // Queue two responses, reset, then reset again partway through the sweep.
    bus.resp_ready = 1'b0;
    next();
    drive_read(1);
    @(negedge clock);
    check("q_rd1_ready", bus.req_ready, 1);
    next();
    drive_read(2);
    @(negedge clock);
    check("q_rd2_ready", bus.req_ready, 1);
    next();
    idle();
    @(negedge clock);
    check("q_one_valid", bus.resp_valid, 1);
    next();
    @(negedge clock);
    check("q_two_valid", bus.resp_valid, 1);
    check("q_two_head", bus.resp_rdata, dpat(1));
    next();
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_sram_en", sram_en, 0);
    next();
    reset = 1'b0;
    sweep_cycles(7);
    reset = 1'b1;
    @(negedge clock);
    check("rst_at7_en", sram_en, 0);
    check("rst_at7_resp_valid", bus.resp_valid, 0);
    next();
    reset = 1'b0;
    sweep_cycles(16);
    drive_read(1);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("resweep_init_done", init_done, 1);
    check("no_stale_valid", bus.resp_valid, 0);
    check("resweep_ready", bus.req_ready, 1);
    next();
    idle();
    @(negedge clock);
    check("resweep_lat1", bus.resp_valid, 0);
    next();
    @(negedge clock);
    check("resweep_valid", bus.resp_valid, 1);
    check("resweep_zeroed", bus.resp_rdata, 0);
    next();
    @(negedge clock);
    check("resweep_popped", bus.resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
